cla_seq_adder_ctrl: RTL

// - Multi-cycle sequencer that adds WIDTH-bit operands on one SLICE_W-bit carry-lookahead slice.
// - Processes one slice per cycle, LSB slice first; a registered carry links consecutive slices.
// - Valid/ready on input and output; serves the core's low-area arithmetic path (multi-cycle ops).

---
 rtl/cla_seq_adder_ctrl_pkg.sv | 22 ++
 rtl/cla_seq_adder_ctrl_slice.sv | 51 +++++
 rtl/cla_seq_adder_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/cla_seq_adder_ctrl_pkg.sv
// Shared types and helpers for the sequential carry-lookahead adder.
// Package name: cla_seq_pkg.
package cla_seq_pkg;

  localparam int SLICE_W_DEF = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Number of slice steps needed to cover a width, top slice zero-padded.
  function automatic int nsl(input int width, input int slice_w);
    return (width + slice_w - 1) / slice_w;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cla_seq_adder_ctrl_slice.sv
// Combinational SLICE_W-bit carry-lookahead slice (module cla_slice); also exposes
// the carry into and out of bit MSB_POS so the parent can derive cout/overflow.
module cla_slice #(
  parameter int SLICE_W = 7,
  parameter int MSB_POS = SLICE_W - 1
) (
  input  logic [SLICE_W-1:0] a_i,
  input  logic [SLICE_W-1:0] b_i,
  input  logic               cin_i,
  output logic [SLICE_W-1:0] sum_o,
  output logic               cout_o,
  output logic               msb_cin_o,
  output logic               msb_cout_o
);

  logic [SLICE_W-1:0] p;
  logic [SLICE_W-1:0] g;
  logic [SLICE_W-1:0] cOut;
  logic [SLICE_W-1:0] cIn;
  logic               prod;

  // Each carry is the flattened sum-of-products form, so no carry waits on its neighbour.
  always_comb begin
    p    = a_i ^ b_i;
    g    = a_i & b_i;
    cOut = '0;
    prod = 1'b0;
    for (int k = 0; k < SLICE_W; k++) begin
      cOut[k] = g[k];
      prod    = p[k];
      for (int j = k - 1; j >= 0; j--) begin
        cOut[k] = cOut[k] | (prod & g[j]);
        prod    = prod & p[j];
      end
      cOut[k] = cOut[k] | (prod & cin_i);
    end
  end

  always_comb begin
    cIn = '0;
    for (int k = 0; k < SLICE_W; k++) begin
      cIn[k] = (k == 0) ? cin_i : cOut[k-1];
    end
  end

  assign sum_o      = p ^ cIn;
  assign cout_o     = cOut[SLICE_W-1];
  assign msb_cin_o  = cIn[MSB_POS];
  assign msb_cout_o = cOut[MSB_POS];

endmodule

// File: rtl/cla_seq_adder_ctrl.sv
// Multi-cycle WIDTH-bit adder that walks one lookahead slice per cycle, LSB first.
// Optional subtract support is built when CLA_SEQ_SUB_EN is defined.
module cla_seq_adder_ctrl
  import cla_seq_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SLICE_W = SLICE_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
`ifdef CLA_SEQ_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int NSL     = nsl(WIDTH, SLICE_W);
  localparam int PW      = NSL * SLICE_W;
  localparam int IDXW    = idx_w(NSL);
  localparam int MSB_POS = (WIDTH - 1) % SLICE_W;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSL - 1);

  state_e            state_q;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              carry_q;
  logic [WIDTH-1:0]  a_q, b_q;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              outValid_q, cout_q, ovf_q;

  logic [WIDTH-1:0]   bEff;
  logic               cinEff;
  logic [PW-1:0]      aPad, bPad;
  logic [SLICE_W-1:0] aSl, bSl, slSum;
  logic               slCout, slMsbCin, slMsbCout;

`ifdef CLA_SEQ_SUB_EN
  // Subtraction is A + ~B + 1; the caller's carry is deliberately dropped.
  assign bEff   = in_sub ? ~in_b : in_b;
  assign cinEff = in_sub ? 1'b1 : in_cin;
`else
  assign bEff   = in_b;
  assign cinEff = in_cin;
`endif

  assign aPad = PW'(a_q);
  assign bPad = PW'(b_q);

  always_comb begin
    aSl = '0;
    bSl = '0;
    for (int s = 0; s < NSL; s++) begin
      if (idx_q == IDXW'(s)) begin
        aSl = aPad[s*SLICE_W +: SLICE_W];
        bSl = bPad[s*SLICE_W +: SLICE_W];
      end
    end
  end

  cla_slice #(
    .SLICE_W (SLICE_W),
    .MSB_POS (MSB_POS)
  ) u_slice (
    .a_i        (aSl),
    .b_i        (bSl),
    .cin_i      (carry_q),
    .sum_o      (slSum),
    .cout_o     (slCout),
    .msb_cin_o  (slMsbCin),
    .msb_cout_o (slMsbCout)
  );

  // Only real result bits are written back; padded sum bits of the top slice are dropped here.
  always_comb begin
    sum_d = sum_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (idx_q == IDXW'(i / SLICE_W)) begin
        sum_d[i] = slSum[i % SLICE_W];
      end
    end
  end

  assign idx_d = idx_q + IDXW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      sum_q      <= '0;
      outValid_q <= 1'b0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= in_a;
            b_q     <= bEff;
            carry_q <= cinEff;
            idx_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q   <= sum_d;
          carry_q <= slCout;
          idx_q   <= idx_d;
          if (idx_q == LAST_IDX) begin
            cout_q     <= slMsbCout;
            ovf_q      <= slMsbCin ^ slMsbCout;
            outValid_q <= 1'b1;
            state_q    <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            outValid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = outValid_q;
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;

endmodule
